// File: rtl/barret_pkg.sv
// Shared constants and helpers for the barret_for_1373 reduction datapath.
package barret_pkg;

    localparam int unsigned BARRET_Q     = 1373;
    localparam int unsigned BARRET_IN_W  = 21;
    localparam int unsigned BARRET_OUT_W = 11;
    localparam int unsigned BARRET_QSQ   = 1885129;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/barret_req_arbiter_if.sv
// Request/response bundle between producer lanes and the shared reducer arbiter.
interface barret_req_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned IN_W    = 21,
    parameter int unsigned OUT_W   = 11
);

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*IN_W-1:0] req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [OUT_W-1:0]        rsp_data;
    logic [ID_W-1:0]         rsp_id;
    logic                    rsp_err;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );

endinterface

// File: rtl/barret_rr_grant.sv
// Round-robin priority picker: first asserted request at or after rr_ptr, modulo NUM_REQ.
module barret_rr_grant #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    winner,
    output logic               any_grant
);

    logic [ID_W:0] idx;

    always_comb begin
        grant     = '0;
        winner    = '0;
        any_grant = 1'b0;
        idx       = '0;
        if (enable) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                // Extra bit lets the wrap be a subtract instead of a general modulo.
                idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
                if (idx >= (ID_W+1)'(NUM_REQ)) begin
                    idx = idx - (ID_W+1)'(NUM_REQ);
                end
                if (!any_grant && req[idx[ID_W-1:0]]) begin
                    any_grant = 1'b1;
                    winner    = idx[ID_W-1:0];
                end
            end
            if (any_grant) begin
                grant[winner] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/barret_req_arbiter.sv
// Round-robin arbiter sharing one combinational barret_for_1373 reducer between requesters.
// Two stages: operand register feeding the reducer, then a response register.
module barret_req_arbiter
    import barret_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = clog2(NUM_REQ),
    parameter int unsigned IN_W    = BARRET_IN_W,
    parameter int unsigned OUT_W   = BARRET_OUT_W,
    parameter int unsigned Q       = BARRET_Q
) (
    input  logic                   clk,
    input  logic                   rst,
    barret_req_arbiter_if.slave    bus,
    output logic [IN_W-1:0]        red_din,
    input  logic [OUT_W-1:0]       red_dout
);

    localparam int unsigned QSQ = Q * Q;

    logic [ID_W-1:0]    rr_ptr_q;
    logic               s1_valid_q;
    logic [ID_W-1:0]    s1_id_q;
    logic               s1_err_q;
    logic               rsp_valid_q;
    logic [OUT_W-1:0]   rsp_data_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic               rsp_err_q;

    logic               s1_free;
    logic               s2_free;
    logic               grant_en;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    winner;
    logic               any_grant;
    logic [IN_W-1:0]    win_data;
    logic [ID_W-1:0]    rr_ptr_d;

    assign s2_free  = !rsp_valid_q || bus.rsp_ready;
    assign s1_free  = !s1_valid_q || s2_free;
    // Gating with rst keeps req_ready low for the whole reset window.
    assign grant_en = s1_free && !rst;

    barret_rr_grant #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_grant (
        .req       (bus.req_valid),
        .rr_ptr    (rr_ptr_q),
        .enable    (grant_en),
        .grant     (grant),
        .winner    (winner),
        .any_grant (any_grant)
    );

    assign win_data = bus.req_data[32'(winner) * IN_W +: IN_W];
    assign rr_ptr_d = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s1_err_q    <= 1'b0;
            red_din     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (s1_valid_q && s2_free) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= s1_err_q ? '0 : red_dout;
                rsp_id_q    <= s1_id_q;
                rsp_err_q   <= s1_err_q;
            end else if (bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end

            if (any_grant) begin
                s1_valid_q <= 1'b1;
                s1_id_q    <= winner;
                s1_err_q   <= (win_data >= IN_W'(QSQ));
                red_din    <= win_data;
                rr_ptr_q   <= rr_ptr_d;
            end else if (s2_free) begin
                s1_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_barret_req_arbiter.sv
// Directed bench for barret_req_arbiter: requester queues feed the DUT, a scoreboard holds the
// expected responses in acceptance order, and a behavioural reducer stands in for barret_for_1373.
module tb_barret_req_arbiter;
    import barret_pkg::*;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned IN_W    = 21;
    localparam int unsigned OUT_W   = 11;

    typedef struct {
        int unsigned data;
        int unsigned id;
        int unsigned err;
        int unsigned cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [IN_W-1:0]  red_din;
    logic [OUT_W-1:0] red_dout;

    barret_req_arbiter_if #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .IN_W    (IN_W),
        .OUT_W   (OUT_W)
    ) bus ();

    barret_req_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .Q       (BARRET_Q)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .red_din  (red_din),
        .red_dout (red_dout)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the shared barret_for_1373 reducer.
    assign red_dout = OUT_W'(red_din % IN_W'(BARRET_Q));

    int unsigned req_q[NUM_REQ][$];
    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cycle = 0;
    int unsigned model_ptr = 0;
    int unsigned acc_count = 0;
    int          first_id = -1;
    bit          check_lat = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int unsigned pending();
        int unsigned n;
        n = sb.size();
        for (int k = 0; k < NUM_REQ; k++) n += req_q[k].size();
        return n;
    endfunction

    // One clock: drive requesters, sample just before the edge, then advance to the negedge.
    task automatic step();
        logic [NUM_REQ-1:0]      v;
        logic [NUM_REQ*IN_W-1:0] d;
        int unsigned             exp_w;
        int unsigned             idx;
        int unsigned             x;
        bit                      found;
        exp_t                    e;
        v = '0;
        d = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_q[k].size() != 0) begin
                v[k]               = 1'b1;
                d[k*IN_W +: IN_W]  = IN_W'(req_q[k][0]);
            end
        end
        bus.req_valid = v;
        bus.req_data  = d;
        #1;
        if (rst) begin
            chk("ready_in_reset", 32'(bus.req_ready), 0);
        end else begin
            chk("ready_subset_of_valid", 32'(bus.req_ready & ~v), 0);
            if (bus.req_ready != '0) begin
                exp_w = 0;
                found = 1'b0;
                for (int i = 0; i < NUM_REQ; i++) begin
                    idx = (model_ptr + i) % NUM_REQ;
                    if (!found && v[idx]) begin
                        exp_w = idx;
                        found = 1'b1;
                    end
                end
                chk("grant_onehot", 32'(bus.req_ready), 32'(1) << exp_w);
                x      = req_q[exp_w].pop_front();
                e.err  = (x >= BARRET_QSQ) ? 1 : 0;
                e.data = (e.err != 0) ? 0 : x % BARRET_Q;
                e.id   = exp_w;
                e.cyc  = cycle;
                sb.push_back(e);
                model_ptr = (exp_w + 1) % NUM_REQ;
                acc_count++;
                if (first_id < 0) first_id = int'(exp_w);
            end
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp_sb_size", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk("rsp_data", 32'(bus.rsp_data), e.data);
                chk("rsp_id", 32'(bus.rsp_id), e.id);
                chk("rsp_err", 32'(bus.rsp_err), e.err);
                if (check_lat) chk("latency", cycle - e.cyc, 2);
            end
        end
        @(posedge clk);
        if (rst) begin
            sb.delete();
            model_ptr = 0;
        end
        @(negedge clk);
        cycle++;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (pending() == 0) break;
            step();
        end
        chk(tag, pending(), 0);
    endtask

    initial begin
        logic [OUT_W-1:0] snap_data;
        logic [ID_W-1:0]  snap_id;
        logic             snap_err;
        bit               have_snap;

        rst           = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;

        // Reset with every requester pending; values also serve the fairness run.
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < NUM_REQ; k++) req_q[k].push_back(BARRET_Q * k + k);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rsp_valid_in_reset", 32'(bus.rsp_valid), 0);
        end
        rst      = 1'b0;
        first_id = -1;
        drain("fairness_drain");
        chk("first_grant_after_reset", 32'(first_id), 0);

        // Boundary values from one requester: back-to-back, fixed two-cycle latency.
        req_q[2] = '{0, 1372, 1373, 1885128};
        check_lat = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check_lat = 1'b0;
        chk("boundary_no_bubbles", pending(), 0);

        // Out-of-range operand followed by an in-range multiple of Q.
        req_q[1] = '{2000000, 2746};
        drain("error_drain");

        // Back-pressure: two accepts fill the pipe, then the held response must not move.
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < NUM_REQ; k++)
                req_q[k].push_back($urandom_range(BARRET_QSQ - 1, 0));
        bus.rsp_ready = 1'b0;
        acc_count     = 0;
        have_snap     = 1'b0;
        snap_data     = '0;
        snap_id       = '0;
        snap_err      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.rsp_valid) begin
                if (have_snap) begin
                    chk("stall_data_stable", 32'(bus.rsp_data), 32'(snap_data));
                    chk("stall_id_stable", 32'(bus.rsp_id), 32'(snap_id));
                    chk("stall_err_stable", 32'(bus.rsp_err), 32'(snap_err));
                end else begin
                    snap_data = bus.rsp_data;
                    snap_id   = bus.rsp_id;
                    snap_err  = bus.rsp_err;
                    have_snap = 1'b1;
                end
            end
        end
        chk("stall_accepts", acc_count, 2);
        bus.rsp_ready = 1'b1;
        drain("backpressure_drain");

        // Reset with both stages full: in-flight work vanishes and the pointer restarts at 0.
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NUM_REQ; k++) req_q[k].push_back(BARRET_Q * 7 + 100 * k);
        bus.rsp_ready = 1'b0;
        step();
        step();
        chk("full_before_reset", 32'(bus.rsp_valid), 1);
        rst = 1'b1;
        step();
        chk("rsp_dropped_by_reset", 32'(bus.rsp_valid), 0);
        rst           = 1'b0;
        first_id      = -1;
        bus.rsp_ready = 1'b1;
        drain("post_reset_drain");
        chk("first_grant_after_mid_reset", 32'(first_id), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/barret_req_arbiter.md
Name: barret_req_arbiter

Overview:
- Shares one combinational barret_for_1373 reducer between NUM_REQ requesters.
- Each requester offers a 21-bit value over a valid/ready handshake.
- The block arbitrates round-robin, registers the winner's value into the reducer input, captures the reducer output into a response register, and returns the residue tagged with the requester ID over a valid/ready handshake.
- Sits between producer lanes (NTT/multiplier lanes) and the shared reduction datapath.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- ID_W, 2, requester ID width, equals clog2(NUM_REQ).
- IN_W, 21, reducer input width.
- OUT_W, 11, reducer output width.
- Q, 1373, modulus; valid input range is 0 ≤ x < Q*Q = 1885129.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_data  in  NUM_REQ*IN_W  packed request values; requester k occupies bits [k*IN_W +: IN_W].
- req_ready  out  NUM_REQ  one-hot accept; asserted only for the granted requester.
- red_din  out  IN_W  registered operand driven to barret_for_1373.din_a.
- red_dout  in  OUT_W  from barret_for_1373.dout_r; combinational function of red_din.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  downstream ready.
- rsp_data  out  OUT_W  residue.
- rsp_id  out  ID_W  originating requester.
- rsp_err  out  1  the operand was ≥ Q*Q; rsp_data is forced to 0.

Behaviour:
- Two-stage pipeline: S1 = operand register (red_din, s1_valid, s1_id, s1_err); S2 = response register (rsp_*).
- Reset (synchronous, rst=1 at a rising edge):
  - s1_valid=0, rsp_valid=0, red_din=0, rsp_data=0, rsp_id=0, rsp_err=0, rr_ptr=0.
  - req_ready=0 while rst=1.
  - In-flight operands are discarded; no response is produced for them.
- S2 advance: s2_free = !rsp_valid || rsp_ready.
  - If s1_valid && s2_free: rsp_data <= (s1_err ? 0 : red_dout), rsp_id <= s1_id, rsp_err <= s1_err, rsp_valid <= 1.
  - Else if rsp_ready: rsp_valid <= 0.
- S1 advance: s1_free = !s1_valid || s2_free.
  - Grant is computed only when s1_free.
  - Winner = first k with req_valid[k]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready[winner]=1 combinationally (depends on req_valid and the internal state only, never on rsp_ready paths beyond s2_free).
  - On grant: red_din <= req_data[winner], s1_id <= winner, s1_err <= (req_data[winner] ≥ Q*Q), s1_valid <= 1, rr_ptr <= (winner+1) mod NUM_REQ.
  - No grant and S1 drained into S2: s1_valid <= 0.
  - rr_ptr is unchanged when there is no grant.
- Latency: accept at edge N → rsp_valid visible after edge N+1 (2 cycles).
- Throughput: 1 result/cycle while rsp_ready=1.
- Back-pressure: with rsp_ready=0 and both stages full, req_ready is all zeros.
  - Requesters must hold req_valid and req_data until accepted.
  - Data is never dropped or duplicated.
- rsp_data, rsp_id and rsp_err are stable while rsp_valid && !rsp_ready.
- A single active requester is granted on every free cycle (no bubbles).
- rr_ptr wraps from NUM_REQ-1 to 0.
- Out-of-range operand (≥ Q*Q) is still consumed; it returns with rsp_err=1 and rsp_data=0.

Decomposition:
- Shared package barret_pkg:
  - Constants BARRET_Q=1373, BARRET_IN_W=21, BARRET_OUT_W=11, BARRET_QSQ=1885129.
  - Function clog2.
- One natural sub-module: barret_rr_grant (round-robin priority picker).
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot grant, encoded winner, any_grant.
- The reducer (barret_for_1373) is instantiated in the top-level next to this block, not inside it.

Test Plan:
- Reset check: assert rst 3 cycles with all req_valid=1 → req_ready=0 and rsp_valid=0 throughout. Release rst → first grant goes to requester 0.
- Boundary values, single requester 2, rsp_ready=1: values 0, 1372, 1373, 1885128 → rsp_data 0, 1372, 0, 1372, each rsp_id=2, back-to-back, 2-cycle latency, no bubbles.
- Fairness: all 4 valid continuously, requester k sends 1373*k+k → grant order 0,1,2,3,0,1… and rsp_data equals the requester index.
- Back-pressure: 4 requesters valid, rsp_ready=0 for 5 cycles then 1 → exactly 2 accepts during the stall, response held stable, then in-order drain. All results match x mod 1373; none lost or duplicated.
- Error path: requester 1 sends 2000000 → rsp_err=1, rsp_data=0, rsp_id=1. The following request 2746 → rsp_err=0, rsp_data=0.
- Reset mid-operation: assert rst while both stages are full → the pending response is dropped, rsp_valid=0 the next cycle, and rr_ptr returns to 0.
